spi_xfer_ctrl: RTL and testbench

Sequences one full-duplex SPI datagram to a stepper driver by driving an internal `piso` transmit shifter. It generates chip select and a divided serial clock in SPI mode 3, and optionally captures the returned status word. It sits between the register/command logic (a request/ready handshake) and the driver pins (`cs_n_out`, `sclk_out`, `mosi_out`, `miso_in`).

---
 rtl/stepper_pkg.sv | 19 +
 rtl/spi_xfer_ctrl_piso.sv | 22 ++
 rtl/spi_xfer_ctrl.sv | 144 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper-driver SPI path.
package stepper_pkg;

    localparam int SPI_DATAGRAM_BITS = 40;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } spi_xfer_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_piso.sv
// Parallel-in serial-out TX shifter; MSB is presented on msb_out and shifted out first.
module piso #(
    parameter int SIZE = 40
) (
    input  logic            clk_in,
    input  logic            en_in,
    input  logic            load_in,
    input  logic [SIZE-1:0] data_in,
    output logic            msb_out
);

    logic [SIZE-1:0] shift_q;

    always_ff @(posedge clk_in) begin
        if (en_in) begin
            shift_q <= load_in ? data_in : {shift_q[SIZE-2:0], 1'b0};
        end
    end

    assign msb_out = shift_q[SIZE-1];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-3 datagram sequencer for the stepper driver (CS, divided SCLK, TX shifter, RX capture).
// RX capture is built only when SPI_XFER_CTRL_READBACK_EN is defined.
//   state | meaning
//   IDLE  | ready for a request, CS high
//   SETUP | CS low, SCLK high, before the first falling edge
//   LOW   | SCLK low half-period, MOSI stable
//   HIGH  | SCLK high half-period, MISO sampled on first cycle
//   HOLD  | CS still low after the last rising edge
//   GAP   | CS high recovery, done pulse on first cycle
module spi_xfer_ctrl
    import stepper_pkg::*;
#(
    parameter int SIZE     = SPI_DATAGRAM_BITS,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            req_in,
    output logic            ready_out,
    input  logic [SIZE-1:0] tx_data_in,
    output logic            done_out,
    output logic [SIZE-1:0] rx_data_out,
    output logic            cs_n_out,
    output logic            sclk_out,
    output logic            mosi_out,
    input  logic            miso_in
);

    localparam int PH_MAX = max_int(max_int(CLK_DIV, CS_SETUP), max_int(CS_HOLD, CS_GAP));
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int BW     = $clog2(SIZE);

    spi_xfer_state_t state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            cs_n_q, sclk_q, ready_q, done_q;
    logic            piso_en, piso_load;
    logic [SIZE-1:0] piso_data;

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        piso_en   = 1'b0;
        piso_load = 1'b0;
        piso_data = tx_data_in;
        unique case (state_q)
            IDLE: begin
                if (req_in && ready_q) begin
                    piso_en   = 1'b1;
                    piso_load = 1'b1;
                    bit_d     = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: if (ph_q == PW'(CS_SETUP - 1)) state_d = LOW;
            LOW:   if (ph_q == PW'(CLK_DIV - 1))  state_d = HIGH;
            HIGH: begin
                if (ph_q == PW'(CLK_DIV - 1)) begin
                    if (bit_q == BW'(SIZE - 1)) begin
                        state_d = HOLD;
                    end else begin
                        piso_en = 1'b1;
                        bit_d   = bit_q + BW'(1);
                        state_d = LOW;
                    end
                end
            end
            HOLD:  if (ph_q == PW'(CS_HOLD - 1)) state_d = GAP;
            GAP:   if (ph_q == PW'(CS_GAP - 1))  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset reloads the shifter with zeros so MOSI is defined from the first edge.
        if (rst_in) begin
            state_d   = IDLE;
            piso_en   = 1'b1;
            piso_load = 1'b1;
            piso_data = '0;
        end
    end

    assign ph_d = (state_d != state_q || state_q == IDLE) ? '0 : ph_q + PW'(1);

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            ph_q    <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            cs_n_q  <= !(state_d inside {SETUP, LOW, HIGH, HOLD});
            sclk_q  <= (state_d != LOW);
            ready_q <= (state_d == IDLE);
            done_q  <= (state_d == GAP) && (state_q != GAP);
        end
    end

    piso #(.SIZE(SIZE)) u_piso (
        .clk_in  (clk_in),
        .en_in   (piso_en),
        .load_in (piso_load),
        .data_in (piso_data),
        .msb_out (mosi_out)
    );

`ifdef SPI_XFER_CTRL_READBACK_EN
    logic [SIZE-1:0] rx_shift_q, rx_data_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            if (state_q == HIGH && ph_q == '0) begin
                rx_shift_q <= {rx_shift_q[SIZE-2:0], miso_in};
            end
            if (state_d == GAP && state_q != GAP) begin
                rx_data_q <= rx_shift_q;
            end
        end
    end

    assign rx_data_out = rx_data_q;
`else
    logic unused_miso;
    assign unused_miso = miso_in;
    assign rx_data_out = '0;
`endif

    assign cs_n_out  = cs_n_q;
    assign sclk_out  = sclk_q;
    assign ready_out = ready_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl: accepts push expected datagrams, a negedge monitor checks them.
module tb_spi_xfer_ctrl;

    localparam int SIZE     = 8;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 3;
    localparam int LAT      = 1 + CS_SETUP + 2 * CLK_DIV * SIZE + CS_HOLD;

    typedef struct {
        logic [SIZE-1:0] tx;
        logic [SIZE-1:0] rx;
        int              acc_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic [SIZE-1:0] tx_data = '0;
    logic            ready_out, done_out, cs_n_out, sclk_out, mosi_out;
    logic [SIZE-1:0] rx_data_out;
    logic            miso_in, miso_drv;

    logic            loop_mode = 1'b0;
    logic            b2b_mode  = 1'b0;
    logic [SIZE-1:0] miso_word = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    int fall_cnt = 0;
    int nrise    = 0;
    int cs_run   = 0;
    int gap_checks = 0;
    bit gap_armed  = 0;
    bit prev_sclk  = 1;
    logic [SIZE-1:0] rise_bits = '0;
    exp_t sb[$];

    spi_xfer_ctrl #(
        .SIZE(SIZE), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .req_in      (req),
        .ready_out   (ready_out),
        .tx_data_in  (tx_data),
        .done_out    (done_out),
        .rx_data_out (rx_data_out),
        .cs_n_out    (cs_n_out),
        .sclk_out    (sclk_out),
        .mosi_out    (mosi_out),
        .miso_in     (miso_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // The slave presents bit i for the whole LOW/HIGH window that follows the i-th falling edge.
    assign miso_drv = (fall_cnt >= 1 && fall_cnt <= SIZE) ? miso_word[SIZE - fall_cnt] : 1'b1;
    assign miso_in  = loop_mode ? mosi_out : miso_drv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] exp_rx(input logic [SIZE-1:0] tx, input logic loop,
                                               input logic [SIZE-1:0] mw);
`ifdef SPI_XFER_CTRL_READBACK_EN
        return loop ? tx : mw;
`else
        return (tx & mw & {SIZE{loop}}) & '0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            fall_cnt  = 0;
            nrise     = 0;
            cs_run    = 0;
            gap_armed = 0;
        end else begin
            if (req && ready_out) begin
                exp_t e;
                e.tx      = tx_data;
                e.rx      = exp_rx(tx_data, loop_mode, miso_word);
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc_cnt++;
                fall_cnt = 0;
                nrise    = 0;
            end
            if (sclk_out && !prev_sclk) begin
                rise_bits = {rise_bits[SIZE-2:0], mosi_out};
                nrise++;
            end
            if (!sclk_out && prev_sclk) fall_cnt++;
            if (done_out) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                    chk("sclk_rises", 64'(nrise), 64'(SIZE));
                    chk("mosi_bits", 64'(rise_bits), 64'(e.tx));
                    chk("rx_data", 64'(rx_data_out), 64'(e.rx));
                end
                if (b2b_mode && req) gap_armed = 1;
            end
            if (cs_n_out) begin
                cs_run++;
            end else begin
                if (cs_run > 0 && gap_armed) begin
                    chk("cs_gap", 64'(cs_run), 64'(CS_GAP + 1));
                    gap_checks++;
                    gap_armed = 0;
                end
                cs_run = 0;
            end
        end
        prev_sclk = sclk_out;
    end

    task automatic send(input logic [SIZE-1:0] w, input logic loop, input logic [SIZE-1:0] mw);
        int n = 0;
        while (!ready_out && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_out) chk("ready_timeout", 64'(ready_out), 64'(1));
        loop_mode = loop;
        miso_word = mw;
        tx_data   = w;
        req       = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
        @(posedge clk); #1;
    endtask

    task automatic wait_fall(input int k);
        int n = 0;
        while (fall_cnt < k && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (fall_cnt < k) chk("fall_timeout", 64'(fall_cnt), 64'(k));
    endtask

    initial begin
        int d0, a0, n;
        logic [SIZE-1:0] w;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", 64'(cs_n_out), 64'(1));
        chk("rst_sclk", 64'(sclk_out), 64'(1));
        chk("rst_ready", 64'(ready_out), 64'(0));
        chk("rst_done", 64'(done_out), 64'(0));
        chk("rst_rx", 64'(rx_data_out), 64'(0));
        chk("rst_mosi", 64'(mosi_out), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", 64'(ready_out), 64'(1));

        send(8'hA5, 1'b0, 8'(($urandom)));
        wait_done(1);

        send(8'h3C, 1'b1, 8'h00);
        wait_done(2);
        repeat (5) @(posedge clk);
        #1;
        chk("rx_held", 64'(rx_data_out), 64'(exp_rx(8'h3C, 1'b1, 8'h00)));

        // Back-to-back with req held high.
        b2b_mode  = 1'b1;
        loop_mode = 1'b0;
        miso_word = 8'h96;
        a0 = acc_cnt;
        d0 = done_cnt;
        tx_data = 8'h01;
        req = 1'b1;
        n = 0;
        while (acc_cnt < a0 + 1 && n < 300) begin @(posedge clk); #1; n++; end
        tx_data = 8'h80;
        while (acc_cnt < a0 + 2 && n < 300) begin @(posedge clk); #1; n++; end
        req = 1'b0;
        chk("b2b_accepts", 64'(acc_cnt - a0), 64'(2));
        wait_done(d0 + 2);
        b2b_mode = 1'b0;
        chk("gap_checked", 64'(gap_checks), 64'(1));

        // Request during LOW of bit 3 must be ignored.
        d0 = done_cnt;
        send(8'h5A, 1'b0, 8'h33);
        wait_fall(4);
        @(posedge clk); #1;
        tx_data = 8'h00;
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(d0 + 1);
        repeat (60) @(posedge clk);
        #1;
        chk("single_done", 64'(done_cnt - d0), 64'(1));

        // One-cycle reset in bit 3 aborts the transfer.
        d0 = done_cnt;
        send(8'hC3, 1'b1, 8'h00);
        wait_fall(4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 64'(cs_n_out), 64'(1));
        chk("abort_sclk", 64'(sclk_out), 64'(1));
        chk("abort_mosi", 64'(mosi_out), 64'(0));
        chk("abort_done", 64'(done_out), 64'(0));
        chk("abort_ready", 64'(ready_out), 64'(0));
        chk("abort_rx", 64'(rx_data_out), 64'(0));
        @(negedge clk);
        chk("abort_ready_rel", 64'(ready_out), 64'(1));
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        send(8'hFF, 1'b0, 8'h0F);
        wait_done(d0 + 1);

        // MISO tied high.
        d0 = done_cnt;
        send(8'h55, 1'b0, 8'hFF);
        wait_done(d0 + 1);

        for (int i = 0; i < 10; i++) begin
            d0 = done_cnt;
            w  = 8'($urandom);
            send(w, 1'($urandom_range(0, 1)), 8'($urandom));
            wait_done(d0 + 1);
        end

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
